// File: rtl/neuron_ctrl.sv
// rtl/neuron_ctrl.sv - 4-phase LIF neuron sequencer with parameter loading.
// Optional refractory hold enabled by defining NEURON_REFRACTORY_EN.
module neuron_ctrl #(
  parameter int REFRACT_STEPS = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  output logic             cfg_ready,
  input  logic             in_valid,
  input  logic             in_spike,
  output logic             in_ready,
  input  logic             result,
  output logic             spike,
  output logic             spike_valid,
  output logic             mux_in,
  output logic             weight_en,
  output logic             decay_en,
  output logic             thresh_en,
  output logic             mult_en,
  output logic             acc_en,
  output logic             comp_en,
  output logic             store_en,
  output logic             weight_rst,
  output logic             decay_rst,
  output logic             thresh_rst,
  output logic             mult_rst,
  output logic             acc_rst,
  output logic             comp_rst,
  output logic             store_rst,
  output logic             out_valid,
  output logic             out_spike,
  output logic             busy,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [2:0] S_CLR   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MULT  = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_COMP  = 3'd5;
  localparam logic [2:0] S_STORE = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       accept;
  logic       refr_now;
  logic       refr_step;

  assign accept = (state == S_IDLE) && in_valid && !cfg_load;

`ifdef NEURON_REFRACTORY_EN
  localparam int REF_W = ($clog2(REFRACT_STEPS + 1) > 3) ? $clog2(REFRACT_STEPS + 1) : 3;
  logic [REF_W-1:0] ref_cnt;
  logic             ref_step_q;

  assign refr_now  = (ref_cnt != '0);
  assign refr_step = ref_step_q;

  // The counter is charged only by a genuine fire, never by a forced-silent step.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt    <= '0;
      ref_step_q <= 1'b0;
    end else if (accept) begin
      ref_step_q <= refr_now;
      if (refr_now) ref_cnt <= ref_cnt - REF_W'(1);
    end else if (state == S_STORE && result && !ref_step_q) begin
      ref_cnt <= REF_W'(REFRACT_STEPS);
    end
  end
`else
  // Without the counter REFRACT_STEPS has no effect; every step is processed normally.
  assign refr_now  = (REFRACT_STEPS < 0);
  assign refr_step = 1'b0;
`endif

  always_comb begin
    state_nx = S_CLR;
    case (state)
      S_CLR:   state_nx = S_IDLE;
      S_IDLE: begin
        if (cfg_load)      state_nx = S_LOAD;
        else if (in_valid) state_nx = S_MULT;
        else               state_nx = S_IDLE;
      end
      S_LOAD:  state_nx = S_IDLE;
      S_MULT:  state_nx = S_ACC;
      S_ACC:   state_nx = S_COMP;
      S_COMP:  state_nx = S_STORE;
      S_STORE: state_nx = S_IDLE;
      default: state_nx = S_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLR;
      spike      <= 1'b0;
      step_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) spike <= in_spike && !refr_now;
      if (state == S_STORE) step_count <= step_count + CNT_W'(1);
    end
  end

  always_comb begin
    cfg_ready   = 1'b0;
    in_ready    = 1'b0;
    spike_valid = 1'b0;
    mux_in      = 1'b0;
    weight_en   = 1'b0;
    decay_en    = 1'b0;
    thresh_en   = 1'b0;
    mult_en     = 1'b0;
    acc_en      = 1'b0;
    comp_en     = 1'b0;
    store_en    = 1'b0;
    weight_rst  = 1'b0;
    decay_rst   = 1'b0;
    thresh_rst  = 1'b0;
    mult_rst    = 1'b0;
    acc_rst     = 1'b0;
    comp_rst    = 1'b0;
    store_rst   = 1'b0;
    out_valid   = 1'b0;
    out_spike   = 1'b0;
    case (state)
      S_CLR: begin
        weight_rst = 1'b1;
        decay_rst  = 1'b1;
        thresh_rst = 1'b1;
        mult_rst   = 1'b1;
        acc_rst    = 1'b1;
        comp_rst   = 1'b1;
        store_rst  = 1'b1;
      end
      S_IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = !cfg_load;
      end
      S_LOAD: begin
        weight_en = 1'b1;
        decay_en  = 1'b1;
        thresh_en = 1'b1;
      end
      S_MULT: begin
        mult_en     = 1'b1;
        mux_in      = 1'b1;
        spike_valid = 1'b1;
        comp_rst    = 1'b1;
      end
      S_ACC: begin
        acc_en      = 1'b1;
        spike_valid = 1'b1;
      end
      S_COMP: comp_en = 1'b1;
      S_STORE: begin
        out_valid = 1'b1;
        out_spike = result && !refr_step;
        store_rst = result || refr_step;
        store_en  = !result && !refr_step;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_neuron_ctrl.sv
// tb/tb_neuron_ctrl.sv - directed bench for neuron_ctrl with a small behavioural LIF datapath.
// Define NEURON_REFRACTORY_EN to also exercise the refractory hold.
module tb_neuron_ctrl;

  logic        clk = 1'b0;
  logic        rst, cfg_load, cfg_ready, in_valid, in_spike, in_ready, result;
  logic        spike, spike_valid, mux_in;
  logic        weight_en, decay_en, thresh_en, mult_en, acc_en, comp_en, store_en;
  logic        weight_rst, decay_rst, thresh_rst, mult_rst, acc_rst, comp_rst, store_rst;
  logic        out_valid, out_spike, busy;
  logic [15:0] step_count;

  int errors = 0;
  int checks = 0;
  int cfg_w = 0, cfg_d = 0, cfg_t = 0;
  int w_r = 0, d_r = 0, t_r = 0, mult_r = 0, acc_r = 0, store_r = 0;
  logic comp_r = 1'b0;

  wire [6:0] all_rst = {weight_rst, decay_rst, thresh_rst, mult_rst, acc_rst, comp_rst, store_rst};
  wire [6:0] all_en  = {weight_en, decay_en, thresh_en, mult_en, acc_en, comp_en, store_en};

  neuron_ctrl #(.REFRACT_STEPS(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_spike(in_spike), .in_ready(in_ready), .result(result),
    .spike(spike), .spike_valid(spike_valid), .mux_in(mux_in),
    .weight_en(weight_en), .decay_en(decay_en), .thresh_en(thresh_en), .mult_en(mult_en),
    .acc_en(acc_en), .comp_en(comp_en), .store_en(store_en),
    .weight_rst(weight_rst), .decay_rst(decay_rst), .thresh_rst(thresh_rst),
    .mult_rst(mult_rst), .acc_rst(acc_rst), .comp_rst(comp_rst), .store_rst(store_rst),
    .out_valid(out_valid), .out_spike(out_spike), .busy(busy), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Datapath: decay factor is d/4, comparator fires when acc >= thresh.
  assign result = comp_r;
  always @(posedge clk) begin
    if (weight_rst) w_r <= 0; else if (weight_en) w_r <= cfg_w;
    if (decay_rst)  d_r <= 0; else if (decay_en)  d_r <= cfg_d;
    if (thresh_rst) t_r <= 0; else if (thresh_en) t_r <= cfg_t;
    if (mult_rst) mult_r <= 0;
    else if (mult_en) mult_r <= mux_in ? (d_r * store_r) >>> 2 : store_r;
    if (acc_rst) acc_r <= 0;
    else if (acc_en) acc_r <= ((spike_valid && spike) ? w_r : 0) + mult_r;
    if (comp_rst) comp_r <= 1'b0; else if (comp_en) comp_r <= (acc_r >= t_r);
    if (store_rst) store_r <= 0; else if (store_en) store_r <= acc_r;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_spike = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic load_cfg(input int w, input int d, input int t);
    cfg_w = w; cfg_d = d; cfg_t = t;
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    tick;
  endtask

  // Runs one timestep from IDLE and reports what was seen in MULT and STORE.
  task automatic run_step(input logic s, output logic seen, output logic osp,
                          output logic st_en, output logic st_rst, output logic crst);
    seen = 1'b0; osp = 1'b0; st_en = 1'b0; st_rst = 1'b0;
    in_valid = 1'b1; in_spike = s;
    tick;
    in_valid = 1'b0;
    crst = comp_rst;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (out_valid) begin
        seen = 1'b1; osp = out_spike; st_en = store_en; st_rst = store_rst;
      end else begin
        tick;
      end
    end
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_spike = 1'b0;
    repeat (3) tick;
    checks++; if (all_rst !== 7'h7f) begin errors++; $display("FAIL rst_during: rst=%b want 1111111", all_rst); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", step_count); end
    rst = 1'b0;
    #1;
    checks++; if (all_rst !== 7'h7f || all_en !== 7'h00) begin errors++; $display("FAIL clr_cycle: rst=%b en=%b want 1111111/0000000", all_rst, all_en); end
    tick;
    checks++; if (all_rst !== 7'h00) begin errors++; $display("FAIL clr_len: rst=%b want 0000000", all_rst); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL idle: busy=%b in_ready=%b cfg_ready=%b want 0/1/1", busy, in_ready, cfg_ready); end
  endtask

  task automatic test_cfg_load;
    logic seen;
    cfg_w = 5; cfg_d = 0; cfg_t = 5;
    cfg_load = 1'b1; in_valid = 1'b1; in_spike = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_prio: in_ready=%b cfg_ready=%b want 0/1", in_ready, cfg_ready); end
    tick;
    cfg_load = 1'b0;
    checks++; if ({weight_en, decay_en, thresh_en} !== 3'b111 || mult_en !== 1'b0) begin errors++; $display("FAIL load_en: wdt=%b mult=%b want 111/0", {weight_en, decay_en, thresh_en}, mult_en); end
    checks++; if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL load_busy: in_ready=%b cfg_ready=%b want 0/0", in_ready, cfg_ready); end
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_load: in_ready=%b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (mult_en !== 1'b1) begin errors++; $display("FAIL held_accept: mult_en=%b want 1", mult_en); end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        checks++; if (out_spike !== 1'b0) begin errors++; $display("FAIL cfg_step_spike: got %b want 0", out_spike); end
      end else tick;
    end
    checks++; if (!seen) begin errors++; $display("FAIL cfg_step_timeout: out_valid=0 want 1"); end
    tick;
    checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL cfg_step_cnt: got %0d want 1", step_count); end
  endtask

  task automatic test_latency;
    do_reset;
    load_cfg(5, 0, 5);
    in_valid = 1'b1; in_spike = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if ({mult_en, mux_in, spike_valid, comp_rst, spike} !== 5'b11111) begin errors++; $display("FAIL lat_mult: got %b want 11111", {mult_en, mux_in, spike_valid, comp_rst, spike}); end
    tick;
    checks++; if ({acc_en, spike_valid, mult_en} !== 3'b110) begin errors++; $display("FAIL lat_acc: got %b want 110", {acc_en, spike_valid, mult_en}); end
    tick;
    checks++; if ({comp_en, acc_en, out_valid} !== 3'b100) begin errors++; $display("FAIL lat_comp: got %b want 100", {comp_en, acc_en, out_valid}); end
    tick;
    checks++; if ({out_valid, out_spike, store_rst, store_en} !== 4'b1110) begin errors++; $display("FAIL lat_store: got %b want 1110", {out_valid, out_spike, store_rst, store_en}); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL lat_cnt_pre: got %0d want 0", step_count); end
    tick;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lat_done: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
    checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL lat_cnt: got %0d want 1", step_count); end
  endtask

  task automatic test_fire;
    logic seen, osp, st_en, st_rst, crst;
    do_reset;
    load_cfg(5, 0, 5);
    run_step(1'b1, seen, osp, st_en, st_rst, crst);
    checks++; if ({seen, osp, st_rst, st_en} !== 4'b1110) begin errors++; $display("FAIL fire: seen/spike/store_rst/store_en=%b want 1110", {seen, osp, st_rst, st_en}); end
    run_step(1'b0, seen, osp, st_en, st_rst, crst);
    checks++; if (crst !== 1'b1) begin errors++; $display("FAIL fire_comp_rst: got %b want 1", crst); end
    checks++; if ({seen, osp} !== 2'b10) begin errors++; $display("FAIL quiet: seen/spike=%b want 10", {seen, osp}); end
  endtask

  task automatic test_decay;
    logic seen, osp, st_en, st_rst, crst;
    logic [5:0] stim, want, got;
    stim = 6'b110011;
    want = 6'b100010;
    do_reset;
    load_cfg(3, 4, 5);
    got = '0;
    for (int i = 0; i < 6; i++) begin
      run_step(stim[i], seen, osp, st_en, st_rst, crst);
      got[i] = osp & seen;
    end
    checks++; if (got !== want) begin errors++; $display("FAIL decay_seq: got %b want %b", got, want); end
    checks++; if (step_count !== 16'd6) begin errors++; $display("FAIL decay_cnt: got %0d want 6", step_count); end
  endtask

  task automatic test_back_to_back;
    int pulses, prev;
    do_reset;
    load_cfg(5, 0, 5);
    pulses = 0; prev = 0;
    in_valid = 1'b1; in_spike = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          checks++; if (k != 4) begin errors++; $display("FAIL b2b_first: cycle %0d want 4", k); end
        end else begin
          checks++; if (k - prev != 5) begin errors++; $display("FAIL b2b_gap: gap %0d want 5", k - prev); end
        end
        prev = k;
      end
    end
    in_valid = 1'b0;
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", pulses); end
    checks++; if (step_count !== 16'd4) begin errors++; $display("FAIL b2b_cnt: got %0d want 4", step_count); end
    in_valid = 1'b1; in_spike = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (acc_en !== 1'b1) begin errors++; $display("FAIL abort_acc: acc_en=%b want 1", acc_en); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (all_rst !== 7'h7f || step_count !== 16'd0) begin errors++; $display("FAIL abort_clr: rst=%b cnt=%0d want 1111111/0", all_rst, step_count); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) pulses++;
      tick;
    end
    checks++; if (pulses != 0 || step_count !== 16'd0) begin errors++; $display("FAIL abort_out: pulses=%0d cnt=%0d want 0/0", pulses, step_count); end
  endtask

`ifdef NEURON_REFRACTORY_EN
  task automatic test_refractory;
    logic seen, osp, st_en, st_rst, crst;
    logic [2:0] got;
    do_reset;
    load_cfg(5, 0, 5);
    run_step(1'b1, seen, osp, st_en, st_rst, crst);
    checks++; if ({seen, osp} !== 2'b11) begin errors++; $display("FAIL refr_fire: got %b want 11", {seen, osp}); end
    got = '0;
    for (int i = 0; i < 3; i++) begin
      run_step(1'b1, seen, osp, st_en, st_rst, crst);
      got[i] = osp & seen;
      if (i == 0) begin
        checks++; if ({st_rst, st_en} !== 2'b10) begin errors++; $display("FAIL refr_store: rst/en=%b want 10", {st_rst, st_en}); end
      end
    end
    checks++; if (got !== 3'b100) begin errors++; $display("FAIL refr_seq: got %b want 100", got); end
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_spike = 1'b0;
    test_reset;
    test_cfg_load;
    test_latency;
    test_fire;
    test_decay;
    test_back_to_back;
`ifdef NEURON_REFRACTORY_EN
    test_refractory;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
